// File: rtl/cb_lockstep_pkg.sv
// Shared types for the lockstep data-side merger.
//   obi_req_t / obi_resp_t : OBI data channel request and response bundles
//   fault_code_e           : cause latched when the merger enters FAULT
//   merger_state_e         : merger FSM states
//   DEFAULT_MAX_SKEW       : default inter-core skew budget in cycles
package cb_lockstep_pkg;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISMATCH = 2'd1,
      FAULT_TIMEOUT  = 2'd2
   } fault_code_e;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_PEER   = 3'd1,
      ST_ISSUE       = 3'd2,
      ST_WAIT_RVALID = 3'd3,
      ST_FAULT       = 3'd4
   } merger_state_e;

   localparam int unsigned DEFAULT_MAX_SKEW = 8;

endpackage

// File: rtl/obi_req_cmp.sv
// Combinational lockstep equivalence of two OBI data requests.
//   req_a, req_b : requests to compare (req bit itself is not compared)
//   match        : 1 when addr, we and be agree, and wdata agrees for writes
module obi_req_cmp
   import cb_lockstep_pkg::*;
(
   input  obi_req_t req_a,
   input  obi_req_t req_b,
   output logic     match
);

   // wdata is a don't-care on reads, so it only participates when we=1
   always_comb begin
      match = (req_a.addr == req_b.addr) &&
              (req_a.we   == req_b.we)   &&
              (req_a.be   == req_b.be)   &&
              (!req_a.we || (req_a.wdata == req_b.wdata));
   end

endmodule

// File: rtl/obi_lockstep_data_merger.sv
// Merges the data-side OBI requests of two lockstepped harts into one bus
// request, broadcasts the bus response to both, and latches a sticky fault
// on divergence or excessive skew, stalling both harts until cleared.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   core_req_i[1:0]  : hart 0/1 data requests
//   core_resp_o[1:0] : gnt/rvalid/rdata returned to hart 0/1
//   bus_req_o        : merged request to the system bus (fields from hart 0)
//   bus_resp_i       : system bus response
//   fault_clr_i      : pulse that clears a latched fault
//   fault_o          : sticky fault flag
//   fault_code_o     : fault cause (NONE/MISMATCH/TIMEOUT)
//   mismatch_cnt_o   : saturating count of faults since reset
module obi_lockstep_data_merger
   import cb_lockstep_pkg::*;
#(
   parameter int unsigned MAX_SKEW = DEFAULT_MAX_SKEW,
   parameter int unsigned CNT_W    = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  obi_req_t [1:0]     core_req_i,
   output obi_resp_t [1:0]    core_resp_o,
   output obi_req_t           bus_req_o,
   input  obi_resp_t          bus_resp_i,
   input  logic               fault_clr_i,
   output logic               fault_o,
   output logic [1:0]         fault_code_o,
   output logic [CNT_W-1:0]   mismatch_cnt_o
);

   localparam logic [8:0] SKEW_LIMIT = 9'(MAX_SKEW);

   merger_state_e    state_q, state_d;
   fault_code_e      code_q, code_d;
   logic [7:0]       skew_q, skew_d;
   logic [8:0]       skew_nxt;
   logic             lead_q, lead_d;
   logic [CNT_W-1:0] cnt_q;
   logic             fault_enter;
   logic             match;
   logic             req0, req1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   obi_req_cmp u_cmp (
      .req_a (core_req_i[0]),
      .req_b (core_req_i[1]),
      .match (match)
   );

   assign req0     = core_req_i[0].req;
   assign req1     = core_req_i[1].req;
   assign skew_nxt = {1'b0, skew_q} + 9'd1;

   // ---- state register ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         code_q  <= FAULT_NONE;
         skew_q  <= '0;
         lead_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         skew_q  <= skew_d;
         lead_q  <= lead_d;
         if (fault_enter) cnt_q <= sat_inc(cnt_q);
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      skew_d  = skew_q;
      lead_d  = lead_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req0 && req1) begin
               if (match) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_FAULT;
                  code_d  = FAULT_MISMATCH;
               end
            end else if (req0 || req1) begin
               lead_d = req1;
               // A budget of one cycle is already exhausted by the lone request
               if (SKEW_LIMIT <= 9'd1) begin
                  state_d = ST_FAULT;
                  code_d  = FAULT_TIMEOUT;
               end else begin
                  state_d = ST_WAIT_PEER;
                  skew_d  = 8'd1;
               end
            end
         end
         ST_WAIT_PEER: begin
            if (!core_req_i[lead_q].req) begin
               // Leader withdrew its request: protocol violation, start over
               state_d = ST_IDLE;
               skew_d  = '0;
            end else if (core_req_i[~lead_q].req) begin
               skew_d = '0;
               if (match) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_FAULT;
                  code_d  = FAULT_MISMATCH;
               end
            end else if (skew_nxt >= SKEW_LIMIT) begin
               state_d = ST_FAULT;
               code_d  = FAULT_TIMEOUT;
               skew_d  = '0;
            end else begin
               skew_d = skew_nxt[7:0];
            end
         end
         ST_ISSUE: begin
            if (bus_resp_i.gnt) state_d = ST_WAIT_RVALID;
         end
         ST_WAIT_RVALID: begin
            if (bus_resp_i.rvalid) state_d = ST_IDLE;
         end
         ST_FAULT: begin
            if (fault_clr_i) begin
               state_d = ST_IDLE;
               code_d  = FAULT_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            code_d  = FAULT_NONE;
            skew_d  = '0;
         end
      endcase
   end

   assign fault_enter = (state_d == ST_FAULT) && (state_q != ST_FAULT);

   // ---- output logic ----
   always_comb begin
      bus_req_o   = '0;
      core_resp_o = '0;
      unique case (state_q)
         ST_ISSUE: begin
            bus_req_o          = core_req_i[0];
            bus_req_o.req      = 1'b1;
            core_resp_o[0].gnt = bus_resp_i.gnt;
            core_resp_o[1].gnt = bus_resp_i.gnt;
         end
         ST_WAIT_RVALID: begin
            if (bus_resp_i.rvalid) begin
               core_resp_o[0].rvalid = 1'b1;
               core_resp_o[1].rvalid = 1'b1;
               core_resp_o[0].rdata  = bus_resp_i.rdata;
               core_resp_o[1].rdata  = bus_resp_i.rdata;
            end
         end
         default: begin
         end
      endcase
   end

   assign fault_o        = (state_q == ST_FAULT);
   assign fault_code_o   = code_q;
   assign mismatch_cnt_o = cnt_q;

endmodule

// File: doc/obi_lockstep_data_merger.md
Name: obi_lockstep_data_merger

Overview:
- Sits directly downstream of the dual cve2 CPU system, on the data side.
- Consumes both harts' OBI data requests and checks them for lockstep equivalence.
- Forwards one merged request to the single system-bus data port and broadcasts the response to both harts.
- Detects divergence (field mismatch) or excessive inter-core skew (timeout), then latches a fault and stalls both cores until software clears it.

Parameters:
- MAX_SKEW, 8, max cycles one core's req may precede the peer's before timeout (1..255).
- CNT_W, 8, width of saturating mismatch counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- core_req_i  in  obi_req_t[1:0]  data requests from hart 0/1
- core_resp_o  out  obi_resp_t[1:0]  gnt/rvalid/rdata to hart 0/1
- bus_req_o  out  obi_req_t  merged request to system bus
- bus_resp_i  in  obi_resp_t  system bus response
- fault_clr_i  in  1  single-cycle pulse, clears fault state
- fault_o  out  1  sticky fault flag
- fault_code_o  out  2  0 NONE, 1 MISMATCH, 2 TIMEOUT
- mismatch_cnt_o  out  CNT_W  count of faults since reset, saturating at all-ones

Behaviour:
- Reset (rst_i high at posedge): state IDLE.
  - bus_req_o all fields 0; core_resp_o all 0.
  - fault_o 0; fault_code_o 0; mismatch_cnt_o 0; skew counter 0.
  - Reset mid-transaction abandons it; no rvalid is forwarded for the abandoned access.
- At most one outstanding bus transaction (cve2 LSU issues one at a time).
- Equivalence: addr, we, be must be equal; wdata compared only when we=1.
- FSM states and transitions:
  - IDLE:
    - both req=1 and equal -> ISSUE.
    - both req=1 and not equal -> FAULT, code MISMATCH.
    - exactly one req=1 -> WAIT_PEER, skew counter=1.
  - WAIT_PEER:
    - peer req=1 -> compare as in IDLE.
    - otherwise counter++; counter reaching MAX_SKEW without peer -> FAULT, code TIMEOUT.
    - If the leading core drops req (OBI violation) -> IDLE.
  - ISSUE:
    - bus_req_o.req=1; addr/we/be/wdata driven combinationally from core 0.
    - core_resp_o[0].gnt = core_resp_o[1].gnt = bus_resp_i.gnt, same cycle, no added latency.
    - gnt=1 -> WAIT_RVALID.
  - WAIT_RVALID:
    - bus_req_o.req=0; core gnt=0.
    - bus_resp_i.rvalid=1 -> both core_resp_o.rvalid=1, rdata=bus_resp_i.rdata, same cycle; next state IDLE.
    - New core reqs are evaluated from the following cycle.
  - FAULT:
    - bus_req_o.req=0; no gnt to either core, so both stall.
    - fault_o=1; fault_code_o holds the cause.
    - fault_clr_i=1 -> IDLE, fault_o=0, code=0.
    - Entering FAULT increments mismatch_cnt_o (saturating) for both causes.
- Latency:
  - Request path: IDLE with both reqs -> bus req asserted next cycle (1-cycle compare register).
  - gnt and rvalid paths: 0 cycles.
- Simultaneous events:
  - fault_clr_i outside FAULT is ignored.
  - A fault and fault_clr_i in the same cycle: the fault wins.
- Bus rvalid arrives at least one cycle after gnt (OBI). rvalid seen outside WAIT_RVALID is dropped, not forwarded.
- Request fields sampled in IDLE/WAIT_PEER are not registered. Cores hold them stable until gnt, per OBI.

Decomposition:
- Shared package cb_lockstep_pkg holds:
  - enum fault_code_e (FAULT_NONE=0, FAULT_MISMATCH=1, FAULT_TIMEOUT=2).
  - FSM state enum merger_state_e.
  - localparam default MAX_SKEW.
- One sub-module, obi_req_cmp: purely combinational equivalence of two obi_req_t (we-gated wdata), output match.

Test Plan:
- Both cores req addr 0x2000_0100, we=0, be=0xF in the same cycle; bus gnt 2 cycles later, rvalid rdata=0xDEADBEEF 1 cycle after -> one bus req, both cores gnt then rvalid with 0xDEADBEEF, fault_o=0.
- Core 0 req at cycle 0, identical core 1 req at cycle 3, MAX_SKEW=8 -> single bus transaction issued at cycle 4, no fault.
- Write, core 0 wdata 0x1234_5678, core 1 wdata 0x1234_5679 -> FAULT, fault_code_o=1, mismatch_cnt_o=1, bus_req_o.req never 1.
- Read with identical addr but differing wdata (we=0) -> no fault, transaction completes.
- Only core 1 req held, MAX_SKEW=8 -> fault_code_o=2 after 8 cycles. fault_clr_i pulse -> fault_o=0; next matched access completes; mismatch_cnt_o stays 1.
- rst_i asserted during WAIT_RVALID, then rvalid arrives -> no rvalid to cores, all outputs at reset values; CNT_W=2 with 5 faults -> counter saturates at 3.
